exe_shift_seq: RTL and testbench
================================

EXE_SHIFT_SEQ -- requirements
Module: exe_shift_seq

Interface
REQ-001 Parameter STEP, 8, maximum shift bits per cycle; legal values are 1, 2, 4 and 8.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  synchronous cancel of any operation in flight.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-007 val_rm  input  32  operand to shift.
REQ-008 shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-009 shift_amt  input  8  shift amount (Rs[7:0], or 5-bit immediate zero-extended).
REQ-010 imm_form  input  1  1 = immediate-shift encoding, 0 = register-shift encoding.
REQ-011 carry_in  input  1  current C flag.
REQ-012 out_valid  output  1  result and carry_out are valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  32  shifted operand.
REQ-015 carry_out  output  1  shifter carry.
REQ-016 busy  output  1  state is not IDLE.

Function
REQ-017 States: IDLE, SHIFT and DONE; accept occurs when in_valid and in_ready are both high; flush has top priority.
REQ-018 On accept, latch the operand, type and carry_in, and compute the effective amount E:
- imm_form=1, amt=0: LSL gives E=0; LSR and ASR give E=32; ROR gives RRX.
- LSL or LSR with amt>32: E=33.
- ASR with amt>32: E=32.
- ROR with amt!=0: E=amt mod 32.
REQ-019 Single-cycle cases go directly to DONE:
- E=0, or register-form amt=0: result=val_rm, carry_out=carry_in.
- ROR with amt!=0 and E=0: result=val_rm, carry_out=val_rm[31].
- RRX: result={carry_in,val_rm[31:1]}, carry_out=val_rm[0].
REQ-020 Otherwise go to SHIFT.
- Each SHIFT cycle shifts by min(remaining, STEP) and decrements the remaining count.
- carry_out tracks the last bit shifted out; ROR rotates.
- When the remaining count reaches 0, go to DONE on the same edge.
REQ-021 Latency: out_valid is first high k cycles after the accept cycle.
- k=1 for the REQ-019 cases.
- k=1+ceil(E/STEP) otherwise.
REQ-022 Results for E>=32:
- LSL/LSR E=32: result 0; carry is val_rm[0] for LSL, val_rm[31] for LSR.
- LSL/LSR E=33: result 0, carry 0.
- ASR E=32: all 32 bits and carry equal val_rm[31].
REQ-023 DONE holds out_valid, result and carry_out stable until out_ready is high, then returns to IDLE on that edge.
- No new accept occurs in that cycle.
REQ-024 flush in any state returns to IDLE next edge.
- out_valid is low next cycle.
- result and carry_out hold their values.
- A flush coinciding with accept or out_ready wins.
REQ-025 in_valid or input changes while the block is not in IDLE are ignored; latched values are used throughout.

Reset
REQ-026 While rst=0 at an edge the block enters IDLE: out_valid=0, result=0, carry_out=0, busy=0, and the remaining count is cleared.
- in_ready=1 from the first cycle after reset.
REQ-027 Reset during SHIFT or DONE abandons the operation; no out_valid pulse follows.

Structure
REQ-028 Package exe_shift_pkg holds:
- shift-type encodings;
- the state enumeration;
- STEP default;
- clamp constants 32 and 33.
REQ-029 One combinational sub-module, exe_shift_step, shifts by 0..STEP bits with carry; exe_shift_seq instantiates it once.

Verification
REQ-030 LSL, register form, val_rm=0x0000_00FF, amt=4, carry_in=0 -> k=2, result=0x0000_0FF0, carry_out=0.
REQ-031 LSR, immediate form, amt=0, val_rm=0x8000_0001 -> E=32, k=5, result=0, carry_out=1; with register form, amt=200 -> k=6, result=0, carry_out=0.
REQ-032 ASR, register form, amt=255, val_rm=0x8000_0000 -> k=5, result=0xFFFF_FFFF, carry_out=1.
REQ-033 ROR, immediate form, amt=0, carry_in=1, val_rm=0x0000_0003 -> k=1, RRX result=0x8000_0001, carry_out=1; with register form, amt=40, val_rm=0x0000_00AB -> k=2, result=0xAB00_0000, carry_out=1.
REQ-034 LSL by 20 (k=4) with out_ready held low 3 cycles -> result is stable and out_valid stays high; then out_ready=1 -> IDLE and in_ready=1 next cycle.
REQ-035 flush, then rst=0 in the second SHIFT cycle of a 33-bit LSL -> IDLE next cycle, no out_valid pulse, and a new request is accepted correctly.

Source files
------------

// File: rtl/exe_shift_pkg.sv
// rtl/exe_shift_pkg.sv - shared encodings, states and constants for the sequential shifter
package exe_shift_pkg;

    localparam int STEP_DEFAULT = 8;

    // Effective-amount clamps: 32 empties the operand, 33 also shifts out the last carry
    localparam logic [5:0] E_CLAMP_32 = 6'd32;
    localparam logic [5:0] E_CLAMP_33 = 6'd33;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/exe_shift_step.sv
// rtl/exe_shift_step.sv - combinational shift of 0..STEP bits with carry tracking
module exe_shift_step
    import exe_shift_pkg::*;
#(
    parameter int STEP = STEP_DEFAULT,
    parameter int AW   = $clog2(STEP + 1)
) (
    input  logic [31:0]   data_in,
    input  logic          carry_in,
    input  shift_type_e   shift_type,
    input  logic [AW-1:0] amt,
    output logic [31:0]   data_out,
    output logic          carry_out
);

    logic [31:0] d;
    logic        c;

    // Unrolled chain of single-bit shifts so the carry is always the last bit out
    always_comb begin
        d = data_in;
        c = carry_in;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(amt)) begin
                case (shift_type)
                    SH_LSL: begin c = d[31]; d = {d[30:0], 1'b0};  end
                    SH_LSR: begin c = d[0];  d = {1'b0, d[31:1]};  end
                    SH_ASR: begin c = d[0];  d = {d[31], d[31:1]}; end
                    default: begin c = d[0]; d = {d[0], d[31:1]};  end
                endcase
            end
        end
    end

    assign data_out  = d;
    assign carry_out = c;

endmodule

// File: rtl/exe_shift_seq.sv
// rtl/exe_shift_seq.sv - multi-cycle barrel-shift sequencer with valid/ready handshakes
module exe_shift_seq
    import exe_shift_pkg::*;
#(
    parameter int STEP = STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] val_rm,
    input  logic [1:0]  shift_type,
    input  logic [7:0]  shift_amt,
    input  logic        imm_form,
    input  logic        carry_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        busy
);

    localparam int AW = $clog2(STEP + 1);

    state_e      state;
    shift_type_e op;
    logic [31:0] work;
    logic        work_c;
    logic [5:0]  remaining;

    shift_type_e req_type;
    logic [5:0]  eff;
    logic        single;
    logic [31:0] single_res;
    logic        single_c;
    logic        amt_big;

    logic [AW-1:0] step_amt;
    logic [5:0]    remaining_next;
    logic [31:0]   step_data;
    logic          step_c;

    assign req_type = shift_type_e'(shift_type);
    assign amt_big  = shift_amt > 8'd32;

    // Decode the effective amount and catch the cases that finish without shifting
    always_comb begin
        eff        = 6'd0;
        single     = 1'b0;
        single_res = val_rm;
        single_c   = carry_in;
        if (shift_amt == 8'd0) begin
            if (imm_form && (req_type == SH_LSR || req_type == SH_ASR)) begin
                eff = E_CLAMP_32;
            end else if (imm_form && req_type == SH_ROR) begin
                single     = 1'b1;
                single_res = {carry_in, val_rm[31:1]};
                single_c   = val_rm[0];
            end else begin
                single = 1'b1;
            end
        end else begin
            case (req_type)
                SH_LSL, SH_LSR: eff = amt_big ? E_CLAMP_33 : shift_amt[5:0];
                SH_ASR:         eff = amt_big ? E_CLAMP_32 : shift_amt[5:0];
                default: begin
                    if (shift_amt[4:0] == 5'd0) begin
                        single   = 1'b1;
                        single_c = val_rm[31];
                    end else begin
                        eff = {1'b0, shift_amt[4:0]};
                    end
                end
            endcase
        end
    end

    assign step_amt       = (remaining > 6'(STEP)) ? AW'(STEP) : remaining[AW-1:0];
    assign remaining_next = remaining - 6'(step_amt);

    exe_shift_step #(
        .STEP (STEP),
        .AW   (AW)
    ) u_step (
        .data_in    (work),
        .carry_in   (work_c),
        .shift_type (op),
        .amt        (step_amt),
        .data_out   (step_data),
        .carry_out  (step_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            op        <= SH_LSL;
            work      <= 32'd0;
            work_c    <= 1'b0;
            remaining <= 6'd0;
            out_valid <= 1'b0;
            result    <= 32'd0;
            carry_out <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op     <= req_type;
                        work   <= val_rm;
                        work_c <= carry_in;
                        if (single) begin
                            result    <= single_res;
                            carry_out <= single_c;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            remaining <= eff;
                            state     <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work      <= step_data;
                    work_c    <= step_c;
                    remaining <= remaining_next;
                    if (remaining_next == 6'd0) begin
                        result    <= step_data;
                        carry_out <= step_c;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_exe_shift_seq.sv
// tb/tb_exe_shift_seq.sv - directed self-checking bench for exe_shift_seq
module tb_exe_shift_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] val_rm = '0;
    logic [1:0]  shift_type = '0;
    logic [7:0]  shift_amt = '0;
    logic        imm_form = 1'b0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        carry_out;
    logic        busy;

    int total = 0;
    int bad = 0;

    exe_shift_seq #(.STEP(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .val_rm     (val_rm),
        .shift_type (shift_type),
        .shift_amt  (shift_amt),
        .imm_form   (imm_form),
        .carry_in   (carry_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carry_out  (carry_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue at a negedge; returns after the accept edge, at the following negedge
    task automatic issue(input logic [1:0] t, input logic [7:0] a, input logic imm,
                         input logic [31:0] v, input logic c);
        shift_type = t; shift_amt = a; imm_form = imm; val_rm = v; carry_in = c;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        val_rm = 32'hDEAD_BEEF; shift_amt = 8'd3; carry_in = ~c;
    endtask

    task automatic run_op(input string tag, input logic [1:0] t, input logic [7:0] a,
                          input logic imm, input logic [31:0] v, input logic c,
                          input int exp_k, input logic [31:0] exp_res, input logic exp_c);
        int k;
        issue(t, a, imm, v, c);
        k = 1;
        while (!out_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_k"}, k, exp_k);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_c"}, {31'd0, carry_out}, {31'd0, exp_c});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_state", {27'd0, in_ready, out_valid, carry_out, busy, 1'b0}, 32'h10);
        check("rst_result", result, 32'd0);

        run_op("lsl4",     2'b00, 8'd4,   1'b0, 32'h0000_00FF, 1'b0, 2, 32'h0000_0FF0, 1'b0);
        run_op("lsr_imm0", 2'b01, 8'd0,   1'b1, 32'h8000_0001, 1'b0, 5, 32'h0,         1'b1);
        run_op("lsr200",   2'b01, 8'd200, 1'b0, 32'h8000_0001, 1'b0, 6, 32'h0,         1'b0);
        run_op("asr255",   2'b10, 8'd255, 1'b0, 32'h8000_0000, 1'b0, 5, 32'hFFFF_FFFF, 1'b1);
        run_op("rrx",      2'b11, 8'd0,   1'b1, 32'h0000_0003, 1'b1, 1, 32'h8000_0001, 1'b1);
        run_op("ror40",    2'b11, 8'd40,  1'b0, 32'h0000_00AB, 1'b0, 2, 32'hAB00_0000, 1'b1);
        run_op("ror32",    2'b11, 8'd32,  1'b0, 32'h8000_1234, 1'b0, 1, 32'h8000_1234, 1'b1);
        run_op("lsl_reg0", 2'b00, 8'd0,   1'b0, 32'h1234_5678, 1'b1, 1, 32'h1234_5678, 1'b1);
        run_op("lsl_imm0", 2'b00, 8'd0,   1'b1, 32'hFFFF_FFFF, 1'b0, 1, 32'hFFFF_FFFF, 1'b0);
        run_op("asr4",     2'b10, 8'd4,   1'b0, 32'hF000_0008, 1'b0, 2, 32'hFF00_0000, 1'b1);
        run_op("lsl9",     2'b00, 8'd9,   1'b0, 32'h0080_0001, 1'b0, 3, 32'h0000_0200, 1'b1);
        run_op("lsl32",    2'b00, 8'd32,  1'b0, 32'h0000_0001, 1'b0, 5, 32'h0,         1'b1);

        // LSL by 20 with the consumer stalling three cycles
        issue(2'b00, 8'd20, 1'b0, 32'h0000_0ABC, 1'b0);
        repeat (2) @(negedge clk);
        check("stall_early", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("stall_k4", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold", {out_valid, busy, in_ready, carry_out, result[27:0]},
                  {1'b1, 1'b1, 1'b0, 1'b0, 28'hBC0_0000});
        end
        check("stall_res", result, 32'hABC0_0000);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall_release", {30'd0, in_ready, out_valid}, 32'd2);

        // Flush during a 33-bit LSL; previous result must survive
        issue(2'b00, 8'd40, 1'b0, 32'hFFFF_FFFF, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("flush_hold", result, 32'hABC0_0000);

        // Reset in the second SHIFT cycle of another 33-bit LSL
        issue(2'b00, 8'd40, 1'b0, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid_idle", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("rst_mid_res", result, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_pulse", seen, 32'd0);

        run_op("after_rst", 2'b01, 8'd4, 1'b0, 32'h0000_00F8, 1'b0, 2, 32'h0000_000F, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
